pipe_mux_n: RTL and testbench
=============================

PIPE_MUX_N -- requirements
Module: pipe_mux_n

Interface
REQ-001 SHALL have parameter WIDTH, default 64, the data width of each input and of the output.
REQ-002 SHALL have parameter NUM_IN, default 4, the number of data inputs; legal range 2..16.
REQ-003 SHALL have parameter SEL_W, default 2, the select width; the integrator sets it so that 2^SEL_W >= NUM_IN.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port d_in, input, NUM_IN*WIDTH bits: packed inputs; input k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-007 SHALL have port sel, input, SEL_W bits: binary select, sampled together with d_in on accept.
REQ-008 SHALL have port in_valid, input, 1 bit: the upstream asserts that d_in and sel are valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the block can accept this cycle.
REQ-010 SHALL have port out_data, output, WIDTH bits: the registered selected word.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream accepts out_data.
REQ-013 SHALL have port flush, input, 1 bit: synchronous discard of all held words.

Function
REQ-014 SHALL accept a word when in_valid=1 and in_ready=1 at a rising clk edge.
REQ-015 SHALL transfer a word out when out_valid=1 and out_ready=1 at a rising clk edge.
REQ-016 SHALL hold the selected input d_in[sel] in a two-entry buffer: a main register driving out_data, plus a skid register.
REQ-017 SHALL present an accepted word on out_data/out_valid on the cycle after acceptance when the main register is empty or is draining; latency is one cycle.
REQ-018 SHALL place an accepted word into the skid register when the main register holds a word and out_ready=0.
REQ-019 SHALL, when the main register drains and the skid register is full, move the skid word into the main register on the same edge; the skid register then refills from the input only when it is empty.
REQ-020 SHALL drive in_ready directly from a register, equal to NOT skid_valid, with no combinational path from out_ready.
REQ-021 SHALL preserve word order; no word is lost or duplicated under any in_valid/out_ready pattern.
REQ-022 SHALL, when simultaneous accept and drain occur with the skid register empty, load the new word into the main register.
REQ-023 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, when flush=1 at an edge, clear both valid flags, discard any same-cycle input, and drive in_ready=1 on the next cycle; flush takes priority over accept and drain.

Reset
REQ-025 SHALL, when reset is asserted, asynchronously force out_valid=0, skid valid=0, in_ready=1, out_data=0, and the skid data to 0.
REQ-026 SHALL, when reset is asserted mid-transfer, discard all held words; the first edge after release behaves as from the empty state.

Configuration
REQ-027 SHALL, when macro PIPE_MUX_SELERR_EN is defined, add output sel_err (1 bit, reset 0).
REQ-028 SHALL, with PIPE_MUX_SELERR_EN defined and an accepted sel >= NUM_IN, store all-zero data and set sel_err; sel_err is sticky until reset.
REQ-029 SHALL, without PIPE_MUX_SELERR_EN, omit the sel_err port and select input 0 for an out-of-range sel.

Verification
REQ-030 SHALL cover basic select: NUM_IN=4, d_in words 0x11..,0x22..,0x33..,0x44.., sel=2, in_valid pulse, out_ready=1 -> out_data=0x33.., out_valid=1 exactly one cycle later, for one cycle.
REQ-031 SHALL cover backpressure: out_ready=0, send words A,B -> out_data=A held, in_ready=0 after B; raise out_ready -> A then B on consecutive cycles, in_ready returns to 1.
REQ-032 SHALL cover streaming: in_valid=1 and out_ready=1 for 100 cycles with sel rotating 0..3 -> 100 outputs in order, no bubbles after the first, in_ready constant 1.
REQ-033 SHALL cover flush: main and skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed words never appear.
REQ-034 SHALL cover async reset: assert reset between clk edges while out_valid=1 -> out_valid=0 and out_data=0 immediately, without waiting for a clk edge.
REQ-035 SHALL cover select error: with PIPE_MUX_SELERR_EN defined, NUM_IN=3, sel=3 accepted -> out_data=0, sel_err=1 and held; without the macro -> out_data=d_in word 0.

Source files
------------

// File: rtl/pipe_mux_n.sv
// pipe_mux_n: NUM_IN:1 word mux into a two-entry skid buffer with a registered in_ready.
// Define PIPE_MUX_SELERR_EN to add a sticky sel_err output and zero the data for out-of-range selects.
module pipe_mux_n #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] d_in,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush
`ifdef PIPE_MUX_SELERR_EN
    ,
    output logic                    sel_err
`endif
);

    logic [WIDTH-1:0] r_main_data, r_skid_data;
    logic             r_main_valid, r_skid_valid, r_in_ready;
    logic [WIDTH-1:0] w_sel_data, w_main_data_nx, w_skid_data_nx;
    logic             w_main_valid_nx, w_skid_valid_nx;
    logic             w_accept, w_drain;

    assign w_accept  = in_valid & r_in_ready;
    assign w_drain   = r_main_valid & out_ready;
    assign in_ready  = r_in_ready;
    assign out_data  = r_main_data;
    assign out_valid = r_main_valid;

    // Out-of-range selects fall through to the default: word 0, or zero with the error option.
    always_comb begin
`ifdef PIPE_MUX_SELERR_EN
        w_sel_data = '0;
`else
        w_sel_data = d_in[WIDTH-1:0];
`endif
        for (int k = 0; k < NUM_IN; k++)
            if (sel == SEL_W'(k)) w_sel_data = d_in[k*WIDTH +: WIDTH];
    end

    always_comb begin
        w_main_data_nx  = r_main_data;
        w_main_valid_nx = r_main_valid;
        w_skid_data_nx  = r_skid_data;
        w_skid_valid_nx = r_skid_valid;
        if (flush) begin
            w_main_valid_nx = 1'b0;
            w_skid_valid_nx = 1'b0;
        end else if (!r_main_valid || w_drain) begin
            w_main_valid_nx = r_skid_valid | w_accept;
            w_main_data_nx  = r_skid_valid ? r_skid_data : (w_accept ? w_sel_data : r_main_data);
            w_skid_valid_nx = 1'b0;
        end else if (w_accept) begin
            w_skid_valid_nx = 1'b1;
            w_skid_data_nx  = w_sel_data;
        end
    end

    // in_ready is registered from the next skid state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_data  <= '0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_data  <= w_main_data_nx;
            r_main_valid <= w_main_valid_nx;
            r_skid_data  <= w_skid_data_nx;
            r_skid_valid <= w_skid_valid_nx;
            r_in_ready   <= ~w_skid_valid_nx;
        end
    end

`ifdef PIPE_MUX_SELERR_EN
    logic r_sel_err;
    logic w_sel_oob;

    assign w_sel_oob = 32'(sel) >= NUM_IN;
    assign sel_err   = r_sel_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sel_err <= 1'b0;
        else if (w_accept && !flush && w_sel_oob) r_sel_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_pipe_mux_n.sv
// tb_pipe_mux_n: directed bench for pipe_mux_n with a scoreboard of expected output words.
// A second instance with NUM_IN=3 exercises the out-of-range select (PIPE_MUX_SELERR_EN aware).
module tb_pipe_mux_n;

    logic         clk = 1'b0;
    logic         reset, flush;
    logic [255:0] d_in;
    logic [1:0]   sel;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [63:0]  out_data;
    logic [191:0] d_in3;
    logic [1:0]   sel3;
    logic         in_valid3, in_ready3, out_valid3, out_ready3;
    logic [63:0]  out_data3;
`ifdef PIPE_MUX_SELERR_EN
    logic         sel_err, sel_err3;
`endif

    logic [63:0] q[$];
    logic [63:0] q3[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_mux_n #(.WIDTH(64), .NUM_IN(4), .SEL_W(2)) dut (
        .clk(clk), .reset(reset), .d_in(d_in), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .flush(flush)
`ifdef PIPE_MUX_SELERR_EN
        , .sel_err(sel_err)
`endif
    );

    pipe_mux_n #(.WIDTH(64), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk(clk), .reset(reset), .d_in(d_in3), .sel(sel3), .in_valid(in_valid3),
        .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready3), .flush(flush)
`ifdef PIPE_MUX_SELERR_EN
        , .sel_err(sel_err3)
`endif
    );

    function automatic logic [255:0] pack4(input logic [63:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [63:0] exp4(input logic [255:0] d, input logic [1:0] s);
        return d[int'(s)*64 +: 64];
    endfunction

    function automatic logic [63:0] exp3(input logic [191:0] d, input logic [1:0] s);
`ifdef PIPE_MUX_SELERR_EN
        return (s == 2'd3) ? 64'd0 : d[int'(s)*64 +: 64];
`else
        return (s == 2'd3) ? d[63:0] : d[int'(s)*64 +: 64];
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: retire/record transfers seen before the edge, then advance to edge+1.
    task automatic step();
        if (!flush) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $error("FAIL sb_main: observed %h expected none", out_data);
                end else chk("sb_main", out_data, q.pop_front());
            end
            if (out_valid3 && out_ready3) begin
                if (q3.size() == 0) begin
                    n_vec++; n_err++;
                    $error("FAIL sb_n3: observed %h expected none", out_data3);
                end else chk("sb_n3", out_data3, q3.pop_front());
            end
            if (in_valid && in_ready) q.push_back(exp4(d_in, sel));
            if (in_valid3 && in_ready3) q3.push_back(exp3(d_in3, sel3));
        end
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
            q3.delete();
        end
    endtask

    task automatic drain_sb();
        in_valid = 1'b0; in_valid3 = 1'b0;
        out_ready = 1'b1; out_ready3 = 1'b1;
        for (int c = 0; c < 8 && (q.size() != 0 || q3.size() != 0); c++) step();
        chk("sb_drained", 64'(q.size() + q3.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0;
        d_in = '0; sel = '0; in_valid = 1'b0; out_ready = 1'b0;
        d_in3 = '0; sel3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, 64'd0);
`ifdef PIPE_MUX_SELERR_EN
        chk("rst_sel_err", sel_err3, 1'b0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // basic select, one-cycle latency, single-cycle valid
        d_in = pack4(64'h1111111111111111, 64'h2222222222222222,
                     64'h3333333333333333, 64'h4444444444444444);
        sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("basic_valid", out_valid, 1'b1);
        chk("basic_data", out_data, 64'h3333333333333333);
        step();
        chk("basic_one_cycle", out_valid, 1'b0);

        // backpressure fills main then skid
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
        d_in = pack4(64'hA0A0A0A0A0A0A0A0, 64'h0, 64'h0, 64'h0);
        step();
        d_in = pack4(64'hB0B0B0B0B0B0B0B0, 64'h0, 64'h0, 64'h0);
        step();
        in_valid = 1'b0;
        chk("bp_hold_a", out_data, 64'hA0A0A0A0A0A0A0A0);
        chk("bp_in_ready_low", in_ready, 1'b0);
        step();
        chk("bp_stable_a", out_data, 64'hA0A0A0A0A0A0A0A0);
        chk("bp_stable_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        step();
        chk("bp_then_b", out_data, 64'hB0B0B0B0B0B0B0B0);
        chk("bp_in_ready_back", in_ready, 1'b1);
        step();
        chk("bp_empty", out_valid, 1'b0);
        drain_sb();

        // streaming with rotating select
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            sel = 2'(i % 4);
            d_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            chk("stream_in_ready", in_ready, 1'b1);
            if (i > 0) chk("stream_no_bubble", out_valid, 1'b1);
            step();
        end
        drain_sb();

        // flush with main and skid full
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
        d_in = pack4(64'h0, 64'hC1C1C1C1C1C1C1C1, 64'h0, 64'h0);
        step();
        d_in = pack4(64'h0, 64'hC2C2C2C2C2C2C2C2, 64'h0, 64'h0);
        step();
        chk("fl_full", in_ready, 1'b0);
        flush = 1'b1;
        d_in = pack4(64'h0, 64'hC3C3C3C3C3C3C3C3, 64'h0, 64'h0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        // flush beats a same-cycle accept and drain
        in_valid = 1'b1; sel = 2'd3;
        d_in = pack4(64'h0, 64'h0, 64'h0, 64'hE1E1E1E1E1E1E1E1);
        step();
        out_ready = 1'b1; flush = 1'b1;
        d_in = pack4(64'h0, 64'h0, 64'h0, 64'hE2E2E2E2E2E2E2E2);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_discard_input", out_valid, 1'b0);
        step();
        step();
        chk("fl_never_appears", out_valid, 1'b0);
        drain_sb();

        // asynchronous reset between edges
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
        d_in = pack4(64'hD0D0D0D0D0D0D0D0, 64'h0, 64'h0, 64'h0);
        step();
        in_valid = 1'b0;
        chk("ar_pre_valid", out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 1'b0);
        chk("ar_out_data", out_data, 64'd0);
        chk("ar_in_ready", in_ready, 1'b1);
        q.delete(); q3.delete();
        #3 reset = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; sel = 2'd3; out_ready = 1'b1;
        d_in = pack4(64'h0, 64'h0, 64'h0, 64'hF0F0F0F0F0F0F0F0);
        step();
        in_valid = 1'b0;
        chk("ar_after_valid", out_valid, 1'b1);
        chk("ar_after_data", out_data, 64'hF0F0F0F0F0F0F0F0);
        drain_sb();

        // out-of-range select on the NUM_IN=3 instance
        d_in3 = {64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
        in_valid3 = 1'b1; sel3 = 2'd3; out_ready3 = 1'b1;
        step();
        chk("se_valid", out_valid3, 1'b1);
`ifdef PIPE_MUX_SELERR_EN
        chk("se_data", out_data3, 64'd0);
        chk("se_flag", sel_err3, 1'b1);
`else
        chk("se_data", out_data3, 64'hAAAAAAAAAAAAAAAA);
`endif
        sel3 = 2'd1;
        step();
        in_valid3 = 1'b0;
        chk("se_in_range", out_data3, 64'hBBBBBBBBBBBBBBBB);
`ifdef PIPE_MUX_SELERR_EN
        chk("se_sticky", sel_err3, 1'b1);
`endif
        drain_sb();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
